ccl_bank_reader: RTL and testbench

Read sequencer for the per-column CCL (column clause index) memory banks. It walks one contiguous address window of every bank in parallel. It drives each bank's read address and read-enable, and captures the 5-bit clause index the bank returns one cycle later. Each index is buffered per column and handed to the PE column over a valid/ready handshake. The block sits between the inference controller (start/done) and the CCL bank array (raddr/ren out, data in).

---
 rtl/ccl_bank_reader.sv | 109 ++++++++++
 tb/tb_ccl_bank_reader.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccl_bank_reader.sv
// Read sequencer for the per-column CCL banks: walks one address window
// in every bank in parallel and streams clause indices per column.
// Ports: clk/rst, start/base_addr/num_entries/busy/done (controller),
// raddr/ren/col_clause_idx_data (bank array), idx_valid/idx_data/idx_ready (PE columns).
module ccl_bank_reader #(
  parameter int N_PE_COL       = 5,
  parameter int DEPTH_CCL_BANK = 4096,
  parameter int FIFO_DEPTH     = 4,
  localparam int AW = $clog2(DEPTH_CCL_BANK)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [AW-1:0]           base_addr,
  input  logic [AW:0]             num_entries,
  output logic                    busy,
  output logic                    done,
  output logic [N_PE_COL*AW-1:0]  raddr_col_clause_idx_bank,
  output logic [N_PE_COL-1:0]     ren_col_clause_idx_bank,
  input  logic [N_PE_COL*5-1:0]   col_clause_idx_data,
  output logic [N_PE_COL-1:0]     idx_valid,
  output logic [N_PE_COL*5-1:0]   idx_data,
  input  logic [N_PE_COL-1:0]     idx_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;
  logic [N_PE_COL-1:0] fin;
  logic run, load;

  assign run  = (state == RUN);
  assign load = (state == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (&fin) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  for (genvar c = 0; c < N_PE_COL; c++) begin : g_col
    logic [AW:0]    cnt;
    logic [AW-1:0]  addr;
    logic           infl;
    logic [4:0]     mem [FIFO_DEPTH];
    logic [PW-1:0]  wp, rp;
    logic [OW-1:0]  occ;
    logic           ren, pop, credit;

    assign pop = (occ != '0) && idx_ready[c];
    // Credit counts the read in flight and frees the slot popped this cycle.
    assign credit = (int'(occ) + int'(infl)) < (FIFO_DEPTH + int'(pop));
    assign ren = run && (cnt != '0) && credit;
    // Column is drained once nothing remains to issue, receive or pop.
    assign fin[c] = (cnt == '0) && !infl && (occ == OW'(pop));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt  <= '0;
        addr <= '0;
        infl <= 1'b0;
        wp   <= '0;
        rp   <= '0;
        occ  <= '0;
      end else begin
        infl <= ren;
        if (load) begin
          cnt  <= num_entries;
          addr <= base_addr;
        end else if (ren) begin
          cnt  <= cnt - 1'b1;
          addr <= (addr == AW'(DEPTH_CCL_BANK - 1)) ? '0 : addr + 1'b1;
        end
        if (infl)
          wp <= (wp == PW'(FIFO_DEPTH - 1)) ? '0 : wp + 1'b1;
        if (pop)
          rp <= (rp == PW'(FIFO_DEPTH - 1)) ? '0 : rp + 1'b1;
        occ <= occ + OW'(infl) - OW'(pop);
      end
    end

    always_ff @(posedge clk) begin
      if (infl) mem[wp] <= col_clause_idx_data[c*5 +: 5];
    end

    assign ren_col_clause_idx_bank[c] = ren;
    assign raddr_col_clause_idx_bank[c*AW +: AW] = ren ? addr : '0;
    assign idx_valid[c] = (occ != '0);
    assign idx_data[c*5 +: 5] = (occ != '0) ? mem[rp] : 5'd0;
  end

endmodule

// File: tb/tb_ccl_bank_reader.sv
// Self-checking bench for ccl_bank_reader: bank model, queue-based
// reference of expected indices, one task per scenario.
module tb_ccl_bank_reader;
  localparam int N = 5;
  localparam int DEPTH = 4096;
  localparam int FD = 4;
  localparam int AW = 12;
  localparam int MAXE = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] num_entries = '0;
  logic busy, done;
  logic [N*AW-1:0] raddr;
  logic [N-1:0] ren;
  logic [5*N-1:0] bank_data = '1;
  logic [N-1:0] idx_valid;
  logic [N-1:0] idx_ready = '1;
  logic [5*N-1:0] idx_data;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ccl_bank_reader #(
    .N_PE_COL(N),
    .DEPTH_CCL_BANK(DEPTH),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .num_entries(num_entries),
    .busy(busy),
    .done(done),
    .raddr_col_clause_idx_bank(raddr),
    .ren_col_clause_idx_bank(ren),
    .col_clause_idx_data(bank_data),
    .idx_valid(idx_valid),
    .idx_data(idx_data),
    .idx_ready(idx_ready)
  );

  int pat_mode = 0;

  function automatic logic [4:0] bank_word(input int c, input int a);
    if (pat_mode != 0) return 5'((a + 7 * c) % 31);
    return 5'(a % 32);
  endfunction

  // Registered bank: new word the cycle after ren, 5'h1F on idle cycles.
  always @(posedge clk)
    for (int c = 0; c < N; c++)
      bank_data[c*5 +: 5] <= ren[c] ?
        bank_word(c, int'(raddr[c*AW +: AW])) : 5'h1F;

  int got [N][MAXE];
  int popc [N][MAXE];
  int ra [N][MAXE];
  int exq [N][MAXE];
  int got_n [N];
  int ren_n [N];
  int ren_by12 [N];
  int last_pop [N];
  int done_cyc, busy_after, hold_err, stale_seen, timed_out;
  int rmode = 0;

  task automatic run_job(input int base, input int n, input int restart);
    logic [N-1:0] stall;
    logic [4:0] pdata [N];
    stall = '0;
    for (int c = 0; c < N; c++) begin
      got_n[c] = 0; ren_n[c] = 0; ren_by12[c] = 0; last_pop[c] = -1;
      pdata[c] = 5'd0;
      for (int i = 0; i < n && i < MAXE; i++)
        exq[c][i] = int'(bank_word(c, (base + i) % DEPTH));
    end
    done_cyc = -1; busy_after = -1; hold_err = 0;
    stale_seen = 0; timed_out = 0;
    @(negedge clk);
    base_addr = AW'(base);
    num_entries = (AW+1)'(n);
    start = 1'b1;
    idx_ready = '1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      start = (cyc == restart);
      if (cyc == restart) begin
        base_addr = AW'(base + 100);
        num_entries = 13'd3;
      end
      case (rmode)
        0: idx_ready = '1;
        1: begin
          idx_ready = '1;
          if (cyc >= 3 && cyc <= 12) idx_ready[2] = 1'b0;
        end
        default: idx_ready = N'($urandom);
      endcase
      #1;
      for (int c = 0; c < N; c++) begin
        if (ren[c]) begin
          if (ren_n[c] < MAXE) ra[c][ren_n[c]] = int'(raddr[c*AW +: AW]);
          ren_n[c]++;
          if (cyc <= 12) ren_by12[c]++;
        end
        if (stall[c] && (!idx_valid[c] || idx_data[c*5 +: 5] !== pdata[c]))
          hold_err++;
        stall[c] = idx_valid[c] && !idx_ready[c];
        pdata[c] = idx_data[c*5 +: 5];
        if (idx_valid[c] && idx_ready[c]) begin
          if (got_n[c] < MAXE) begin
            got[c][got_n[c]] = int'(idx_data[c*5 +: 5]);
            popc[c][got_n[c]] = cyc;
          end
          got_n[c]++;
          last_pop[c] = cyc;
          if (idx_data[c*5 +: 5] == 5'h1F) stale_seen++;
        end
      end
      if (done_cyc >= 0) begin
        busy_after = int'(busy);
        break;
      end
      if (done) done_cyc = cyc;
    end
    start = 1'b0;
    idx_ready = '1;
    if (busy_after < 0) timed_out = 1;
  endtask

  task automatic test_reset();
    int bad;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, ren, raddr, idx_valid, idx_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: outputs %h required 0",
               {busy, done, ren, raddr, idx_valid, idx_data});
    end
    rst = 1'b0;
    base_addr = 12'd0; num_entries = 13'd8; start = 1'b1;
    idx_ready = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (idx_valid !== '1) begin
      n_fail++;
      $display("FAIL reset_prefill: idx_valid %b required 11111", idx_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, ren, raddr, idx_valid, idx_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_midrun: outputs %h required 0",
               {busy, done, ren, raddr, idx_valid, idx_data});
    end
    @(negedge clk);
    rst = 1'b0;
    idx_ready = '1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (ren !== '0 || busy !== 1'b0 || idx_valid !== '0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_quiet: %0d active cycles required 0", bad);
    end
  endtask

  task automatic test_stream();
    pat_mode = 0; rmode = 0;
    run_job(10, 6, 0);
    n_checks++;
    if (timed_out != 0 || done_cyc != 9) begin
      n_fail++;
      $display("FAIL stream_done: cycle %0d required 9", done_cyc);
    end
    n_checks++;
    if (busy_after != 0) begin
      n_fail++;
      $display("FAIL stream_busy_drop: busy %0d required 0", busy_after);
    end
    for (int c = 0; c < N; c++) begin
      n_checks++;
      if (got_n[c] != 6) begin
        n_fail++;
        $display("FAIL stream_count col%0d: %0d required 6", c, got_n[c]);
      end
      for (int i = 0; i < 6 && i < got_n[c]; i++) begin
        n_checks++;
        if (got[c][i] != 10 + i || popc[c][i] != 3 + i
            || ra[c][i] != 10 + i) begin
          n_fail++;
          $display("FAIL stream_item col%0d[%0d]: data %0d cyc %0d addr %0d required %0d/%0d/%0d",
                   c, i, got[c][i], popc[c][i], ra[c][i], 10 + i, 3 + i, 10 + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    pat_mode = 0; rmode = 1;
    run_job(10, 6, 0);
    n_checks++;
    if (ren_by12[2] != FD) begin
      n_fail++;
      $display("FAIL bp_issue col2: %0d reads required %0d", ren_by12[2], FD);
    end
    n_checks++;
    if (hold_err != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d unstable cycles required 0", hold_err);
    end
    n_checks++;
    if (got[2][0] != 10) begin
      n_fail++;
      $display("FAIL bp_head col2: %0d required 10", got[2][0]);
    end
    for (int c = 0; c < N; c++) begin
      if (c != 2) begin
        n_checks++;
        if (last_pop[c] != 8) begin
          n_fail++;
          $display("FAIL bp_on_time col%0d: last pop %0d required 8", c, last_pop[c]);
        end
      end
      n_checks++;
      if (got_n[c] != 6) begin
        n_fail++;
        $display("FAIL bp_count col%0d: %0d required 6", c, got_n[c]);
      end
      for (int i = 0; i < 6 && i < got_n[c]; i++) begin
        n_checks++;
        if (got[c][i] != exq[c][i]) begin
          n_fail++;
          $display("FAIL bp_order col%0d[%0d]: %0d required %0d", c, i, got[c][i], exq[c][i]);
        end
      end
    end
    n_checks++;
    if (timed_out != 0 || done_cyc != last_pop[2] + 1) begin
      n_fail++;
      $display("FAIL bp_done: cycle %0d required %0d", done_cyc, last_pop[2] + 1);
    end
  endtask

  task automatic test_wrap();
    int wa [4];
    wa[0] = 4094; wa[1] = 4095; wa[2] = 0; wa[3] = 1;
    pat_mode = 0; rmode = 0;
    run_job(4094, 4, 0);
    n_checks++;
    if (timed_out != 0 || done_cyc != 7) begin
      n_fail++;
      $display("FAIL wrap_done: cycle %0d required 7", done_cyc);
    end
    for (int c = 0; c < N; c++) begin
      n_checks++;
      if (got_n[c] != 4 || ren_n[c] != 4) begin
        n_fail++;
        $display("FAIL wrap_count col%0d: pops %0d reads %0d required 4", c, got_n[c], ren_n[c]);
      end
      for (int i = 0; i < 4 && i < got_n[c] && i < ren_n[c]; i++) begin
        n_checks++;
        if (ra[c][i] != wa[i] || got[c][i] != exq[c][i]) begin
          n_fail++;
          $display("FAIL wrap_item col%0d[%0d]: addr %0d data %0d required %0d/%0d",
                   c, i, ra[c][i], got[c][i], wa[i], exq[c][i]);
        end
      end
    end
  endtask

  task automatic test_zero_and_restart();
    int tot;
    pat_mode = 0; rmode = 0;
    run_job(0, 0, 0);
    tot = 0;
    for (int c = 0; c < N; c++) tot += ren_n[c] + got_n[c];
    n_checks++;
    if (timed_out != 0 || done_cyc != 2) begin
      n_fail++;
      $display("FAIL zero_done: cycle %0d required 2", done_cyc);
    end
    n_checks++;
    if (tot != 0) begin
      n_fail++;
      $display("FAIL zero_activity: %0d reads/pops required 0", tot);
    end
    run_job(20, 5, 2);
    n_checks++;
    if (timed_out != 0 || done_cyc != 8) begin
      n_fail++;
      $display("FAIL restart_done: cycle %0d required 8", done_cyc);
    end
    for (int c = 0; c < N; c++) begin
      n_checks++;
      if (got_n[c] != 5) begin
        n_fail++;
        $display("FAIL restart_count col%0d: %0d required 5", c, got_n[c]);
      end
      for (int i = 0; i < 5 && i < got_n[c]; i++) begin
        n_checks++;
        if (got[c][i] != exq[c][i]) begin
          n_fail++;
          $display("FAIL restart_order col%0d[%0d]: %0d required %0d", c, i, got[c][i], exq[c][i]);
        end
      end
    end
  endtask

  task automatic test_stale_random();
    int b, n;
    pat_mode = 1; rmode = 2;
    for (int j = 0; j < 4; j++) begin
      b = int'($urandom_range(0, DEPTH - 1));
      n = int'($urandom_range(1, 20));
      run_job(b, n, 0);
      n_checks++;
      if (timed_out != 0 || stale_seen != 0 || hold_err != 0) begin
        n_fail++;
        $display("FAIL stale_job%0d: timeout %0d stale %0d hold %0d required 0/0/0",
                 j, timed_out, stale_seen, hold_err);
      end
      for (int c = 0; c < N; c++) begin
        n_checks++;
        if (got_n[c] != n) begin
          n_fail++;
          $display("FAIL stale_count job%0d col%0d: %0d required %0d", j, c, got_n[c], n);
        end
        for (int i = 0; i < n && i < got_n[c]; i++) begin
          n_checks++;
          if (got[c][i] != exq[c][i]) begin
            n_fail++;
            $display("FAIL stale_order job%0d col%0d[%0d]: %0d required %0d",
                     j, c, i, got[c][i], exq[c][i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap();
    test_zero_and_restart();
    test_stale_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
